adderseq_ctrl: RTL and testbench
================================

ADDERSEQ_CTRL -- requirements
Module: adderseq_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 16, total operand width.
REQ-002 SHALL have parameter SLICE, default 4, adder slice width processed per cycle; NBITS SHALL be an integer multiple of SLICE.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands a, b, cin offered.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have ports a, b  input  NBITS  operands, and cin  input  1  carry-in.
REQ-008 SHALL have port out_valid  output  1  result r, cout valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports r  output  NBITS  sum, and cout  output  1  final carry-out.
REQ-011 SHALL have port busy  output  1  high in RUN state.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: in_ready=1; on in_valid, capture a, b into operand shift registers, cin into carry register, clear slice counter, go to RUN.
REQ-014 RUN: each cycle add the low SLICE bits of both operand registers plus carry register via one SLICE-wide ripple adder; shift the SLICE sum bits into r from the MSB end; store adder carry-out into the carry register; shift operand registers right by SLICE; increment counter.
REQ-015 RUN SHALL last exactly NBITS/SLICE cycles; on the last slice go to DONE with cout equal to final carry.
REQ-016 DONE: out_valid=1, r and cout held stable; on out_ready go to IDLE.
REQ-017 Latency from accepting handshake (in_valid & in_ready) to out_valid high SHALL be NBITS/SLICE+1 cycles.
REQ-018 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored with no operand capture.
REQ-019 Result SHALL equal (a + b + cin) mod 2^NBITS in r, bit NBITS in cout, for all inputs including all-ones wrap-around.
REQ-020 Simultaneous out_ready and in_valid in DONE SHALL only complete the output handshake; the new operand is accepted next cycle in IDLE.
REQ-021 When NBITS==SLICE, RUN SHALL last one cycle.

Reset
REQ-022 rst high at a clock edge SHALL force IDLE from any state, including mid-RUN, discarding partial results.
REQ-023 Reset values: in_ready=1 after reset released... during reset in_ready=0; out_valid=0, busy=0, r=0, cout=0, counter=0, carry register=0.

Configuration
REQ-024 Macro ADDERSEQ_OVF_EN defined SHALL add port ovf  output  1, signed two's-complement overflow (carry into MSB XOR carry out of MSB), valid with out_valid, reset 0.
REQ-025 Without ADDERSEQ_OVF_EN the ovf port and its logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-026 State encoding (IDLE, RUN, DONE) as a typedef enum SHALL live in package adderseq_pkg, with the state width constant.
REQ-027 The SLICE-wide adder SHALL be one instantiated sub-module, addergen_st with NBITS=SLICE; counter width SHALL be derived from $clog2(NBITS/SLICE) (minimum 1).

Verification
REQ-028 Reset then a=16'h1234, b=16'h4321, cin=0 -> after 5 cycles out_valid=1, r=16'h5555, cout=0.
REQ-029 a=16'hFFFF, b=16'h0000, cin=1 -> r=16'h0000, cout=1 (full carry ripple across all slices).
REQ-030 Hold out_ready=0 for 10 cycles in DONE -> r, cout, out_valid stable; in_valid pulses ignored, in_ready=0.
REQ-031 Assert rst in 2nd RUN cycle -> next cycle IDLE, out_valid=0, r=0, busy=0; following add of 16'h0001+16'h0001 gives r=16'h0002.
REQ-032 With ADDERSEQ_OVF_EN: a=16'h7FFF, b=16'h0001, cin=0 -> r=16'h8000, cout=0, ovf=1; a=16'hFFFF, b=16'h0001 -> ovf=0, cout=1.
REQ-033 Back-to-back: out_ready and in_valid held high continuously with 100 random operands -> each result matches reference sum, one result per NBITS/SLICE+2 cycles.

Source files
------------

// File: rtl/adderseq_pkg.sv
// Shared types for the sequential slice adder.
// FSM state encoding and counter width helper.
package adderseq_pkg;

  localparam int STW = 2;

  typedef enum logic [STW-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int nsl);
    return (nsl > 1) ? $clog2(nsl) : 1;
  endfunction

endpackage

// File: rtl/addergen_st.sv
// Combinational ripple-carry adder, NBITS wide.
// Used by adderseq_ctrl as the per-cycle slice adder.
module addergen_st #(
  parameter int NBITS = 4
) (
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic             cin,
  output logic [NBITS-1:0] s,
  output logic             cout
);

  logic [NBITS:0] c;

  // ripple the carry bit by bit
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < NBITS; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[NBITS];

endmodule

// File: rtl/adderseq_ctrl.sv
// Sequential adder: one SLICE-wide add per cycle, IDLE/RUN/DONE.
// Optional ADDERSEQ_OVF_EN adds a signed overflow flag output.
module adderseq_ctrl
  import adderseq_pkg::*;
#(
  parameter int NBITS = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] r,
  output logic             cout,
`ifdef ADDERSEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NSL = NBITS / SLICE;
  localparam int CW  = cnt_w(NSL);
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  state_t            state;
  logic [NBITS-1:0]  opa;
  logic [NBITS-1:0]  opb;
  logic              carry;
  logic [CW-1:0]     cnt;
  logic [SLICE-1:0]  sum;
  logic              co;
  logic [NBITS-1:0]  r_nxt;

  addergen_st #(
    .NBITS (SLICE)
  ) u_add (
    .a    (opa[SLICE-1:0]),
    .b    (opb[SLICE-1:0]),
    .cin  (carry),
    .s    (sum),
    .cout (co)
  );

  // new slice sum enters r from the MSB end
  generate
    if (NBITS == SLICE) begin : g_one
      assign r_nxt = sum;
    end else begin : g_many
      assign r_nxt = {sum, r[NBITS-1:SLICE]};
    end
  endgenerate

`ifdef ADDERSEQ_OVF_EN
  logic ovf_nxt;
  // carry into MSB recovered from the MSB sum bit
  assign ovf_nxt = co ^ (opa[SLICE-1] ^ opb[SLICE-1]
                       ^ sum[SLICE-1]);
`endif

  // control FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      r         <= '0;
      cout      <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      opa       <= '0;
      opb       <= '0;
`ifdef ADDERSEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            opa      <= a;
            opb      <= b;
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          r     <= r_nxt;
          carry <= co;
          opa   <= opa >> SLICE;
          opb   <= opb >> SLICE;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout      <= co;
`ifdef ADDERSEQ_OVF_EN
            ovf       <= ovf_nxt;
`endif
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adderseq_ctrl.sv
// Self-checking bench for adderseq_ctrl (NBITS=16, SLICE=4).
// Vector table, scoreboard queue and corner-case sequences.
module tb_adderseq_ctrl;

  localparam int NB  = 16;
  localparam int NSL = 4;
  localparam int LAT = NSL + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] a;
  logic [NB-1:0] b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] r;
  logic          cout;
  logic          busy;
`ifdef ADDERSEQ_OVF_EN
  logic          ovf;
`endif

  adderseq_ctrl #(
    .NBITS (NB),
    .SLICE (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .cout      (cout),
`ifdef ADDERSEQ_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  typedef struct {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic          cin;
    logic [NB-1:0] r;
    logic          cout;
  } vec_t;

  typedef struct {
    logic [NB-1:0] r;
    logic          cout;
    logic          ovf;
  } exp_t;

  exp_t sbq[$];
  int   compared;
  int   mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // called at a negedge; leaves one negedge after handshake
  task automatic send(input logic [NB-1:0] ta,
                      input logic [NB-1:0] tb,
                      input logic tc,
                      input logic [NB-1:0] er,
                      input logic ec);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_ready_timeout", 0, 1);
    end else begin
      a        = ta;
      b        = tb;
      cin      = tc;
      in_valid = 1'b1;
      e.r      = er;
      e.cout   = ec;
      e.ovf    = (ta[NB-1] == tb[NB-1]) &&
                 (er[NB-1] != ta[NB-1]);
      sbq.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      chk("busy_run", {31'd0, busy}, 1);
      chk("in_ready_run", {31'd0, in_ready}, 0);
    end
  endtask

  task automatic collect(input string nm);
    int   n;
    exp_t e;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk({nm, "_out_timeout"}, 0, 1);
    end else begin
      chk({nm, "_latency"}, n, LAT);
      if (sbq.size() == 0) begin
        chk({nm, "_sb_empty"}, 0, 1);
      end else begin
        e = sbq.pop_front();
        chk({nm, "_r"}, {16'd0, r}, {16'd0, e.r});
        chk({nm, "_cout"}, {31'd0, cout},
            {31'd0, e.cout});
`ifdef ADDERSEQ_OVF_EN
        chk({nm, "_ovf"}, {31'd0, ovf},
            {31'd0, e.ovf});
`endif
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({nm, "_ov_clr"}, {31'd0, out_valid}, 0);
    end
  endtask

  initial begin
    vec_t          tbl[10];
    logic [NB:0]   s;
    exp_t          e;
    int            n, sent, got, last, cyc;
    bit            acc;

    compared   = 0;
    mismatched = 0;
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[5] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0};
    tbl[6] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
    tbl[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    tbl[8] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[9] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_r", {16'd0, r}, 0);
    chk("rst_cout", {31'd0, cout}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 1);

    // table of vectors
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin,
           tbl[i].r, tbl[i].cout);
      collect($sformatf("vec%0d", i));
    end

    // hold in DONE, ignore in_valid pulses
    send(16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reach_done", {31'd0, out_valid}, 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("hold_sb_r", {16'd0, r}, {16'd0, e.r});
      chk("hold_sb_cout", {31'd0, cout}, {31'd0, e.cout});
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2) == 0;
      a        = 16'hDEAD;
      b        = 16'hBEEF;
      cin      = 1'b1;
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 1);
      chk("hold_r", {16'd0, r}, 32'h0000FFFF);
      chk("hold_cout", {31'd0, cout}, 0);
      chk("hold_in_ready", {31'd0, in_ready}, 0);
    end

    // out_ready with in_valid in DONE: only output handshake
    in_valid  = 1'b1;
    a         = 16'h0001;
    b         = 16'h0002;
    cin       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("sim_ov_clr", {31'd0, out_valid}, 0);
    chk("sim_no_capture", {31'd0, busy}, 0);
    chk("sim_in_ready", {31'd0, in_ready}, 1);
    e.r    = 16'h0003;
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    chk("sim_accept_busy", {31'd0, busy}, 1);
    collect("sim_next");

    // reset during second RUN cycle
    send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ov", {31'd0, out_valid}, 0);
    chk("mid_rst_r", {16'd0, r}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_cout", {31'd0, cout}, 0);
    rst = 1'b0;
    if (sbq.size() != 0) void'(sbq.pop_back());
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, in_ready}, 1);
    send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
    collect("after_rst");

    // back-to-back random stream
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = NB'($urandom);
    b         = NB'($urandom);
    cin       = 1'($urandom);
    sent = 0;
    got  = 0;
    last = -1;
    cyc  = 0;
    acc  = 1'b0;
    while (got < 100 && cyc < 3000) begin
      if (in_valid && in_ready) begin
        s      = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        e.r    = s[NB-1:0];
        e.cout = s[NB];
        e.ovf  = (a[NB-1] == b[NB-1]) &&
                 (s[NB-1] != a[NB-1]);
        sbq.push_back(e);
        sent++;
        acc = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("b2b_sb_empty", 0, 1);
        end else begin
          e = sbq.pop_front();
          chk("b2b_r", {16'd0, r}, {16'd0, e.r});
          chk("b2b_cout", {31'd0, cout},
              {31'd0, e.cout});
`ifdef ADDERSEQ_OVF_EN
          chk("b2b_ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
        end
        if (last >= 0) chk("b2b_period", cyc - last, NSL + 2);
        last = cyc;
        got++;
      end
      if (acc) begin
        acc = 1'b0;
        if (sent < 100) begin
          a   = NB'($urandom);
          b   = NB'($urandom);
          cin = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", got, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
